// File: rtl/hpdcache_pkg.sv
`default_nettype none
// hpdcache_pkg: cache configuration record and derived refill constants.
// Revision 1.0
package hpdcache_pkg;

  typedef struct packed {
    int unsigned clWords;
    int unsigned wordWidth;
    int unsigned memDataWidth;
    int unsigned mshrSets;
    int unsigned mshrWays;
    int unsigned setWidth;
    int unsigned tagWidth;
    int unsigned wayWidth;
    int unsigned mshrSetWidth;
    int unsigned mshrWayWidth;
    int unsigned reqTidWidth;
    int unsigned reqSidWidth;
  } hpdcache_cfg_t;

  localparam hpdcache_cfg_t HPDCACHE_DEFAULT_CFG = '{
    clWords:      8,
    wordWidth:    64,
    memDataWidth: 128,
    mshrSets:     4,
    mshrWays:     2,
    setWidth:     7,
    tagWidth:     20,
    wayWidth:     2,
    mshrSetWidth: 2,
    mshrWayWidth: 1,
    reqTidWidth:  8,
    reqSidWidth:  3
  };

  // Number of memory beats that make up one cache line.
  function automatic int unsigned hpdcache_refill_beats(input hpdcache_cfg_t cfg);
    return (cfg.clWords * cfg.wordWidth) / cfg.memDataWidth;
  endfunction

  function automatic int unsigned hpdcache_mshr_id_width(input hpdcache_cfg_t cfg);
    return cfg.mshrSetWidth + cfg.mshrWayWidth;
  endfunction

  // Index width that stays legal (>= 1 bit) for single-entry structures.
  function automatic int unsigned hpdcache_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_mshr_refill_buf.sv
`default_nettype none
// hpdcache_mshr_refill_buf: beat-indexed line buffer with a word-indexed read port.
// Revision 1.0
module hpdcache_mshr_refill_buf
  import hpdcache_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned MEM_W  = 128,
  parameter int unsigned WORD_W = 64,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned IDX_W  = hpdcache_cnt_width(BEATS),
  parameter int unsigned RD_W   = hpdcache_cnt_width(WORDS)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [MEM_W-1:0]         wr_data,
  input  logic [RD_W-1:0]          rd_idx,
  output logic [BEATS*MEM_W-1:0]   line,
  output logic [WORD_W-1:0]        word
);

  logic [MEM_W-1:0]  mem_q [BEATS];
  logic [WORD_W-1:0] words [WORDS];

  // Data storage carries no reset: a line is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_line
    assign line[b*MEM_W +: MEM_W] = mem_q[b];
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign words[w] = line[w*WORD_W +: WORD_W];
  end

  assign word = words[rd_idx];

endmodule
`default_nettype wire

// File: rtl/hpdcache_mshr_refill.sv
`default_nettype none
// hpdcache_mshr_refill: collects refill beats, acknowledges the MSHR entry, installs the line.
// Revision 1.0
module hpdcache_mshr_refill
  import hpdcache_pkg::*;
#(
  parameter hpdcache_cfg_t HPDcacheCfg = HPDCACHE_DEFAULT_CFG,
  parameter type hpdcache_tag_t     = logic [HPDcacheCfg.tagWidth-1:0],
  parameter type hpdcache_set_t     = logic [HPDcacheCfg.setWidth-1:0],
  parameter type hpdcache_way_t     = logic [HPDcacheCfg.wayWidth-1:0],
  parameter type hpdcache_word_t    = logic [hpdcache_cnt_width(HPDcacheCfg.clWords)-1:0],
  parameter type hpdcache_req_tid_t = logic [HPDcacheCfg.reqTidWidth-1:0],
  parameter type hpdcache_req_sid_t = logic [HPDcacheCfg.reqSidWidth-1:0],
  parameter type mshr_set_t         = logic [HPDcacheCfg.mshrSetWidth-1:0],
  parameter type mshr_way_t         = logic [HPDcacheCfg.mshrWayWidth-1:0]
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,

  input  logic                                                   mem_rsp_valid_i,
  output logic                                                   mem_rsp_ready_o,
  input  logic [hpdcache_mshr_id_width(HPDcacheCfg)-1:0]         mem_rsp_id_i,
  input  logic [HPDcacheCfg.memDataWidth-1:0]                    mem_rsp_data_i,
  input  logic                                                   mem_rsp_error_i,
  input  logic                                                   mem_rsp_last_i,

  output logic                                                   refill_req_o,
  input  logic                                                   refill_gnt_i,

  output logic                                                   mshr_ack_o,
  output logic                                                   mshr_ack_cs_o,
  output mshr_set_t                                              mshr_ack_set_o,
  output mshr_way_t                                              mshr_ack_way_o,
  input  hpdcache_req_tid_t                                      mshr_ack_req_id_i,
  input  hpdcache_req_sid_t                                      mshr_ack_src_id_i,
  input  hpdcache_set_t                                          mshr_ack_cache_set_i,
  input  hpdcache_way_t                                          mshr_ack_cache_way_i,
  input  hpdcache_tag_t                                          mshr_ack_cache_tag_i,
  input  hpdcache_word_t                                         mshr_ack_word_i,
  input  logic                                                   mshr_ack_need_rsp_i,
  input  logic                                                   mshr_ack_is_prefetch_i,
  input  logic                                                   mshr_ack_wback_i,

  output logic                                                   refill_write_valid_o,
  input  logic                                                   refill_write_ready_i,
  output hpdcache_set_t                                          refill_set_o,
  output hpdcache_way_t                                          refill_way_o,
  output hpdcache_tag_t                                          refill_tag_o,
  output logic [HPDcacheCfg.clWords*HPDcacheCfg.wordWidth-1:0]   refill_data_o,
  output logic                                                   refill_dirty_o,

  output logic                                                   core_rsp_valid_o,
  output hpdcache_req_tid_t                                      core_rsp_req_id_o,
  output hpdcache_req_sid_t                                      core_rsp_src_id_o,
  output logic [HPDcacheCfg.wordWidth-1:0]                       core_rsp_data_o,
  output logic                                                   core_rsp_error_o,

  output logic                                                   busy_o
);

  localparam int unsigned BEATS  = hpdcache_refill_beats(HPDcacheCfg);
  localparam int unsigned BEAT_W = hpdcache_cnt_width(BEATS);
  localparam int unsigned ID_W   = hpdcache_mshr_id_width(HPDcacheCfg);
  localparam int unsigned SET_W  = HPDcacheCfg.mshrSetWidth;
  localparam int unsigned LINE_W = HPDcacheCfg.clWords * HPDcacheCfg.wordWidth;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ACK_REQ = 3'd2,
    ST_ACK_RD  = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  state_e                          state_q, state_d;
  logic [BEAT_W-1:0]               beat_cnt_q;
  logic                            err_q;
  logic [ID_W-1:0]                 id_q;
  logic                            beat_accept;

  hpdcache_req_tid_t               meta_req_id_q;
  hpdcache_req_sid_t               meta_src_id_q;
  hpdcache_set_t                   meta_set_q;
  hpdcache_way_t                   meta_way_q;
  hpdcache_tag_t                   meta_tag_q;
  hpdcache_word_t                  meta_word_q;
  logic                            meta_need_rsp_q;
  logic                            meta_prefetch_q;
  logic                            meta_wback_q;

  logic [LINE_W-1:0]               buf_line;
  logic [HPDcacheCfg.wordWidth-1:0] buf_word;

  assign beat_accept = mem_rsp_valid_i & mem_rsp_ready_o;

  hpdcache_mshr_refill_buf #(
    .BEATS  (BEATS),
    .MEM_W  (HPDcacheCfg.memDataWidth),
    .WORD_W (HPDcacheCfg.wordWidth),
    .WORDS  (HPDcacheCfg.clWords),
    .IDX_W  (BEAT_W),
    .RD_W   ($bits(hpdcache_word_t))
  ) u_buf (
    .clk     (clk_i),
    .wr_en   (beat_accept),
    .wr_idx  (beat_cnt_q),
    .wr_data (mem_rsp_data_i),
    .rd_idx  (meta_word_q),
    .line    (buf_line),
    .word    (buf_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (mem_rsp_valid_i) begin
          state_d = mem_rsp_last_i ? ST_ACK_REQ : ST_COLLECT;
        end
      end
      ST_ACK_REQ: begin
        if (refill_gnt_i) begin
          state_d = ST_ACK_RD;
        end
      end
      ST_ACK_RD: begin
        // Errored lines skip the cache write; a response only if someone waits for it.
        if (!err_q) begin
          state_d = ST_WRITE;
        end else if (mshr_ack_need_rsp_i && !mshr_ack_is_prefetch_i) begin
          state_d = ST_RSP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (refill_write_ready_i) begin
          state_d = (meta_need_rsp_q && !meta_prefetch_q) ? ST_RSP : ST_IDLE;
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rsp_ready_o      = 1'b0;
    refill_req_o         = 1'b0;
    mshr_ack_o           = 1'b0;
    mshr_ack_cs_o        = 1'b0;
    mshr_ack_set_o       = '0;
    mshr_ack_way_o       = '0;
    refill_write_valid_o = 1'b0;
    refill_set_o         = '0;
    refill_way_o         = '0;
    refill_tag_o         = '0;
    refill_data_o        = '0;
    refill_dirty_o       = 1'b0;
    core_rsp_valid_o     = 1'b0;
    core_rsp_req_id_o    = '0;
    core_rsp_src_id_o    = '0;
    core_rsp_data_o      = '0;
    core_rsp_error_o     = 1'b0;
    busy_o               = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE, ST_COLLECT: mem_rsp_ready_o = 1'b1;
      ST_ACK_REQ: begin
        refill_req_o   = 1'b1;
        mshr_ack_o     = refill_gnt_i;
        mshr_ack_cs_o  = refill_gnt_i;
        mshr_ack_set_o = id_q[SET_W-1:0];
        mshr_ack_way_o = id_q[ID_W-1:SET_W];
      end
      ST_WRITE: begin
        refill_write_valid_o = 1'b1;
        refill_set_o         = meta_set_q;
        refill_way_o         = meta_way_q;
        refill_tag_o         = meta_tag_q;
        refill_data_o        = buf_line;
        refill_dirty_o       = meta_wback_q;
      end
      ST_RSP: begin
        core_rsp_valid_o  = 1'b1;
        core_rsp_req_id_o = meta_req_id_q;
        core_rsp_src_id_o = meta_src_id_q;
        core_rsp_data_o   = buf_word;
        core_rsp_error_o  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q      <= '0;
      err_q           <= 1'b0;
      id_q            <= '0;
      meta_req_id_q   <= '0;
      meta_src_id_q   <= '0;
      meta_set_q      <= '0;
      meta_way_q      <= '0;
      meta_tag_q      <= '0;
      meta_word_q     <= '0;
      meta_need_rsp_q <= 1'b0;
      meta_prefetch_q <= 1'b0;
      meta_wback_q    <= 1'b0;
    end else begin
      if (beat_accept) begin
        beat_cnt_q <= mem_rsp_last_i ? '0 : beat_cnt_q + 1'b1;
        // First beat of a line starts a fresh error accumulation.
        err_q      <= ((state_q == ST_IDLE) ? 1'b0 : err_q) | mem_rsp_error_i;
        if (state_q == ST_IDLE) begin
          id_q <= mem_rsp_id_i;
        end
      end
      if (state_q == ST_ACK_RD) begin
        meta_req_id_q   <= mshr_ack_req_id_i;
        meta_src_id_q   <= mshr_ack_src_id_i;
        meta_set_q      <= mshr_ack_cache_set_i;
        meta_way_q      <= mshr_ack_cache_way_i;
        meta_tag_q      <= mshr_ack_cache_tag_i;
        meta_word_q     <= mshr_ack_word_i;
        meta_need_rsp_q <= mshr_ack_need_rsp_i;
        meta_prefetch_q <= mshr_ack_is_prefetch_i;
        meta_wback_q    <= mshr_ack_wback_i;
      end
    end
  end

  a_last_on_final_beat: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (beat_accept && mem_rsp_last_i) |-> (beat_cnt_q == LAST_BEAT)
  );

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mshr_refill.sv
`default_nettype none
// tb_hpdcache_mshr_refill: directed refill scenarios checked through a cycle-stamped scoreboard.
// Revision 1.0
module tb_hpdcache_mshr_refill;
  import hpdcache_pkg::*;

  localparam hpdcache_cfg_t CFG = '{
    clWords: 8, wordWidth: 64, memDataWidth: 128, mshrSets: 4, mshrWays: 2,
    setWidth: 7, tagWidth: 20, wayWidth: 2, mshrSetWidth: 2, mshrWayWidth: 1,
    reqTidWidth: 8, reqSidWidth: 3
  };
  localparam int CW = 576;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         mem_rsp_valid_i, mem_rsp_ready_o;
  logic [2:0]   mem_rsp_id_i;
  logic [127:0] mem_rsp_data_i;
  logic         mem_rsp_error_i, mem_rsp_last_i;
  logic         refill_req_o, refill_gnt_i;
  logic         mshr_ack_o, mshr_ack_cs_o;
  logic [1:0]   mshr_ack_set_o;
  logic [0:0]   mshr_ack_way_o;
  logic [7:0]   mshr_ack_req_id_i;
  logic [2:0]   mshr_ack_src_id_i;
  logic [6:0]   mshr_ack_cache_set_i;
  logic [1:0]   mshr_ack_cache_way_i;
  logic [19:0]  mshr_ack_cache_tag_i;
  logic [2:0]   mshr_ack_word_i;
  logic         mshr_ack_need_rsp_i, mshr_ack_is_prefetch_i, mshr_ack_wback_i;
  logic         refill_write_valid_o, refill_write_ready_i;
  logic [6:0]   refill_set_o;
  logic [1:0]   refill_way_o;
  logic [19:0]  refill_tag_o;
  logic [511:0] refill_data_o;
  logic         refill_dirty_o;
  logic         core_rsp_valid_o;
  logic [7:0]   core_rsp_req_id_o;
  logic [2:0]   core_rsp_src_id_o;
  logic [63:0]  core_rsp_data_o;
  logic         core_rsp_error_o;
  logic         busy_o;

  hpdcache_mshr_refill #(.HPDcacheCfg(CFG)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_error_i(mem_rsp_error_i), .mem_rsp_last_i(mem_rsp_last_i),
    .refill_req_o(refill_req_o), .refill_gnt_i(refill_gnt_i),
    .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
    .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
    .mshr_ack_req_id_i(mshr_ack_req_id_i), .mshr_ack_src_id_i(mshr_ack_src_id_i),
    .mshr_ack_cache_set_i(mshr_ack_cache_set_i), .mshr_ack_cache_way_i(mshr_ack_cache_way_i),
    .mshr_ack_cache_tag_i(mshr_ack_cache_tag_i), .mshr_ack_word_i(mshr_ack_word_i),
    .mshr_ack_need_rsp_i(mshr_ack_need_rsp_i), .mshr_ack_is_prefetch_i(mshr_ack_is_prefetch_i),
    .mshr_ack_wback_i(mshr_ack_wback_i),
    .refill_write_valid_o(refill_write_valid_o), .refill_write_ready_i(refill_write_ready_i),
    .refill_set_o(refill_set_o), .refill_way_o(refill_way_o), .refill_tag_o(refill_tag_o),
    .refill_data_o(refill_data_o), .refill_dirty_o(refill_dirty_o),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_req_id_o(core_rsp_req_id_o),
    .core_rsp_src_id_o(core_rsp_src_id_o), .core_rsp_data_o(core_rsp_data_o),
    .core_rsp_error_o(core_rsp_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int cyc; logic [1:0] set; logic [0:0] way; } ack_t;
  typedef struct { int cyc; logic [6:0] set; logic [1:0] way; logic [19:0] tag;
                   logic [511:0] data; logic dirty; } wr_t;
  typedef struct { int cyc; logic [7:0] req_id; logic [2:0] src_id;
                   logic [63:0] data; logic err; } rsp_t;

  ack_t ack_q[$];
  wr_t  wr_q[$];
  rsp_t rsp_q[$];
  ack_t ae;
  wr_t  we;
  rsp_t re;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit stalled = 1'b0;
  logic [CW-1:0] snap;

  // Entry contents the MSHR model returns for the line in flight.
  logic [7:0]  m_req;
  logic [2:0]  m_src;
  logic [6:0]  m_set;
  logic [1:0]  m_way;
  logic [19:0] m_tag;
  logic [2:0]  m_word;
  logic        m_need, m_pref, m_wb;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive_meta(input bit garbage);
    mshr_ack_req_id_i      = garbage ? ~m_req  : m_req;
    mshr_ack_src_id_i      = garbage ? ~m_src  : m_src;
    mshr_ack_cache_set_i   = garbage ? ~m_set  : m_set;
    mshr_ack_cache_way_i   = garbage ? ~m_way  : m_way;
    mshr_ack_cache_tag_i   = garbage ? ~m_tag  : m_tag;
    mshr_ack_word_i        = garbage ? ~m_word : m_word;
    mshr_ack_need_rsp_i    = garbage ? ~m_need : m_need;
    mshr_ack_is_prefetch_i = garbage ? ~m_pref : m_pref;
    mshr_ack_wback_i       = garbage ? ~m_wb   : m_wb;
  endtask

  // MSHR model: contents are valid only in the cycle following the ack.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && mshr_ack_o) begin
        @(posedge clk_i); #1 drive_meta(1'b0);
        @(posedge clk_i); #1 drive_meta(1'b1);
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni && mon_en) begin
      if (mshr_ack_o) begin
        chk("ack_gnt", CW'(refill_gnt_i), CW'(1'b1));
        chk("ack_cs", CW'(mshr_ack_cs_o), CW'(1'b1));
        if (ack_q.size() == 0) begin
          checks++; $display("FAIL ack_unexpected at cycle %0d", cyc);
        end else begin
          ae = ack_q.pop_front();
          chk("ack_cycle", CW'(cyc), CW'(ae.cyc));
          chk("ack_set", CW'(mshr_ack_set_o), CW'(ae.set));
          chk("ack_way", CW'(mshr_ack_way_o), CW'(ae.way));
        end
      end
      if (refill_write_valid_o) begin
        if (!refill_write_ready_i) begin
          chk("stall_mem_ready", CW'(mem_rsp_ready_o), CW'(1'b0));
          if (stalled)
            chk("stall_payload", CW'({refill_set_o, refill_way_o, refill_tag_o,
                                       refill_dirty_o, refill_data_o}), snap);
          snap = CW'({refill_set_o, refill_way_o, refill_tag_o, refill_dirty_o, refill_data_o});
          stalled = 1'b1;
        end else begin
          stalled = 1'b0;
          if (wr_q.size() == 0) begin
            checks++; $display("FAIL write_unexpected at cycle %0d", cyc);
          end else begin
            we = wr_q.pop_front();
            chk("wr_cycle", CW'(cyc), CW'(we.cyc));
            chk("wr_set", CW'(refill_set_o), CW'(we.set));
            chk("wr_way", CW'(refill_way_o), CW'(we.way));
            chk("wr_tag", CW'(refill_tag_o), CW'(we.tag));
            chk("wr_data", CW'(refill_data_o), CW'(we.data));
            chk("wr_dirty", CW'(refill_dirty_o), CW'(we.dirty));
          end
        end
      end
      if (core_rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          checks++; $display("FAIL rsp_unexpected at cycle %0d", cyc);
        end else begin
          re = rsp_q.pop_front();
          chk("rsp_cycle", CW'(cyc), CW'(re.cyc));
          chk("rsp_req_id", CW'(core_rsp_req_id_o), CW'(re.req_id));
          chk("rsp_src_id", CW'(core_rsp_src_id_o), CW'(re.src_id));
          chk("rsp_data", CW'(core_rsp_data_o), CW'(re.data));
          chk("rsp_error", CW'(core_rsp_error_o), CW'(re.err));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_ready"}, CW'(mem_rsp_ready_o), CW'(1'b1));
    chk({tag, "_busy"}, CW'(busy_o), CW'(1'b0));
    chk({tag, "_strobes"}, CW'({refill_req_o, mshr_ack_o, mshr_ack_cs_o,
                                refill_write_valid_o, core_rsp_valid_o}), CW'(5'b0));
    chk({tag, "_ack_idx"}, CW'({mshr_ack_set_o, mshr_ack_way_o}), CW'(3'b0));
    chk({tag, "_wr_payload"}, CW'({refill_set_o, refill_way_o, refill_tag_o,
                                   refill_dirty_o, refill_data_o}), CW'(0));
    chk({tag, "_rsp_payload"}, CW'({core_rsp_req_id_o, core_rsp_src_id_o,
                                    core_rsp_data_o, core_rsp_error_o}), CW'(0));
  endtask

  task automatic set_meta(input logic [7:0] req, input logic [2:0] src, input logic [6:0] set,
                          input logic [1:0] way, input logic [19:0] tag, input logic [2:0] word,
                          input logic need, input logic pref, input logic wb);
    m_req = req; m_src = src; m_set = set; m_way = way; m_tag = tag;
    m_word = word; m_need = need; m_pref = pref; m_wb = wb;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [2:0] id, input logic err,
                           input logic last);
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = d; mem_rsp_id_i = id;
    mem_rsp_error_i = err; mem_rsp_last_i = last;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0; mem_rsp_last_i = 1'b0; mem_rsp_error_i = 1'b0;
  endtask

  // Returns t, the cycle in which the last beat is presented.
  task automatic send_line(input logic [127:0] beats [4], input logic [2:0] id,
                           input logic [3:0] errm, output int t);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) t = cyc;
      send_beat(beats[i], id, errm[i], i == 3);
    end
  endtask

  task automatic push_expect(input int t, input int gd, input int wd, input bit err,
                             input logic [2:0] id, input logic [127:0] beats [4]);
    ack_t a; wr_t w; rsp_t r; logic [127:0] bsel;
    a.cyc = t + 1 + gd; a.set = id[1:0]; a.way = id[2];
    ack_q.push_back(a);
    bsel = beats[int'(m_word) / 2];
    r.data = m_word[0] ? bsel[127:64] : bsel[63:0];
    r.req_id = m_req; r.src_id = m_src;
    if (!err) begin
      w.cyc = t + 3 + gd + wd; w.set = m_set; w.way = m_way; w.tag = m_tag;
      w.data = {beats[3], beats[2], beats[1], beats[0]}; w.dirty = m_wb;
      wr_q.push_back(w);
      if (m_need && !m_pref) begin
        r.cyc = t + 4 + gd + wd; r.err = 1'b0; rsp_q.push_back(r);
      end
    end else if (m_need && !m_pref) begin
      r.cyc = t + 3 + gd; r.err = 1'b1; rsp_q.push_back(r);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 40) begin @(posedge clk_i); #1; n++; end
    if (busy_o) begin checks++; $display("FAIL %s_timeout: busy_o still 1 after 40 cycles", tag); end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] la [4];
  logic [127:0] lb [4];
  logic [127:0] lc [4];
  int t;

  initial begin
    la[0] = 128'h0000_0000_0000_0001_1111_1111_1111_1110;
    la[1] = 128'h2222_3333_4444_5555_6666_7777_8888_9999;
    la[2] = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
    la[3] = 128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_FFFF_0000;
    lb[0] = 128'h1000_0000_0000_0000_0000_0000_0000_0001;
    lb[1] = 128'h2000_0000_0000_0001_0000_0000_0000_0002;
    lb[2] = 128'h3000_0000_0000_0002_0000_0000_0000_0003;
    lb[3] = 128'h4000_0000_0000_0003_0000_0000_0000_0004;
    lc[0] = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    lc[1] = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;
    lc[2] = 128'h99AA_BBCC_DDEE_FF00_ABAB_CDCD_EFEF_0101;
    lc[3] = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

    rst_ni = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_id_i = '0; mem_rsp_data_i = '0;
    mem_rsp_error_i = 1'b0; mem_rsp_last_i = 1'b0;
    refill_gnt_i = 1'b1; refill_write_ready_i = 1'b1;
    set_meta(8'h00, 3'd0, 7'h00, 2'd0, 20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive_meta(1'b1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1 rst_ni = 1'b1; mon_en = 1'b1;
    @(posedge clk_i); #1;

    // Basic 4-beat refill with immediate grant.
    set_meta(8'h11, 3'd2, 7'h1A, 2'd2, 20'hABCDE, 3'd5, 1'b1, 1'b0, 1'b0);
    send_line(la, 3'b101, 4'b0000, t);
    push_expect(t, 0, 0, 1'b0, 3'b101, la);
    wait_idle("basic");

    // Grant withheld for three cycles.
    refill_gnt_i = 1'b0;
    send_line(la, 3'b101, 4'b0000, t);
    push_expect(t, 3, 0, 1'b0, 3'b101, la);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("gnt_wait_req", CW'(refill_req_o), CW'(1'b1));
      chk("gnt_wait_no_ack", CW'(mshr_ack_o), CW'(1'b0));
      @(posedge clk_i); #1;
    end
    refill_gnt_i = 1'b1;
    wait_idle("gnt_delay");

    // Error on beat 1: ack still issued, no write, errored response.
    set_meta(8'h22, 3'd5, 7'h05, 2'd1, 20'h12345, 3'd2, 1'b1, 1'b0, 1'b1);
    send_line(lb, 3'b010, 4'b0010, t);
    push_expect(t, 0, 0, 1'b1, 3'b010, lb);
    wait_idle("error");

    // Prefetch with write-back: dirty install, no response, idle at t+4.
    set_meta(8'h33, 3'd1, 7'h7F, 2'd3, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 1'b1);
    send_line(lc, 3'b011, 4'b0000, t);
    push_expect(t, 0, 0, 1'b0, 3'b011, lc);
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("prefetch_idle_busy", CW'(busy_o), CW'(1'b0));
    chk("prefetch_idle_ready", CW'(mem_rsp_ready_o), CW'(1'b1));
    wait_idle("prefetch");

    // Cache write held off for five cycles.
    refill_write_ready_i = 1'b0;
    set_meta(8'h44, 3'd6, 7'h40, 2'd0, 20'h0F0F0, 3'd0, 1'b1, 1'b0, 1'b1);
    send_line(lb, 3'b100, 4'b0000, t);
    push_expect(t, 0, 5, 1'b0, 3'b100, lb);
    repeat (7) @(posedge clk_i);
    #1 refill_write_ready_i = 1'b1;
    wait_idle("wr_stall");

    // Reset in the middle of a line, then a clean line afterwards.
    send_beat(lc[0], 3'b110, 1'b1, 1'b0);
    send_beat(lc[1], 3'b110, 1'b0, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("midline_reset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    set_meta(8'h55, 3'd3, 7'h2B, 2'd1, 20'h54321, 3'd1, 1'b1, 1'b0, 1'b0);
    send_line(la, 3'b001, 4'b0000, t);
    push_expect(t, 0, 0, 1'b0, 3'b001, la);
    wait_idle("post_reset");

    repeat (3) @(posedge clk_i);
    chk("ack_q_drained", CW'(ack_q.size()), CW'(0));
    chk("wr_q_drained", CW'(wr_q.size()), CW'(0));
    chk("rsp_q_drained", CW'(rsp_q.size()), CW'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpdcache_mshr_refill.md
# hpdcache_mshr_refill

Refill-response handler that closes the miss loop opened by MSHR allocation. It collects multi-beat refill data from the memory response channel into a line buffer, arbitrates for and issues the MSHR acknowledge, and captures the entry metadata the MSHR returns one cycle later. It then writes the refilled line into the cache and, if the entry requires one, emits the core response. It sits between the memory read-response interface and the miss-handler pipeline, alongside the MSHR.

## Interface

Parameters:
- HPDcacheCfg, '0, cache configuration: clWords, wordWidth, memDataWidth, mshrSets, mshrWays, setWidth, tagWidth, mshrSetWidth.
- hpdcache_tag_t / hpdcache_set_t / hpdcache_way_t / hpdcache_word_t / hpdcache_req_tid_t / hpdcache_req_sid_t, logic, cache field types.
- mshr_set_t / mshr_way_t, logic, MSHR index types.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mem_rsp_valid_i / mem_rsp_ready_o  in/out  1  refill beat handshake
- mem_rsp_id_i  in  way+set bits  MSHR id; way in the upper bits, set in the lower bits
- mem_rsp_data_i  in  memDataWidth  beat data
- mem_rsp_error_i / mem_rsp_last_i  in  1  beat error; final beat
- refill_req_o / refill_gnt_i  out/in  1  request and grant for the MSHR ack slot from the miss pipeline
- mshr_ack_o / mshr_ack_cs_o  out  1  MSHR ack strobe and chip select
- mshr_ack_set_o / mshr_ack_way_o  out  mshr_set_t / mshr_way_t  entry being acknowledged
- mshr_ack_req_id_i, mshr_ack_src_id_i, mshr_ack_cache_set_i, mshr_ack_cache_way_i, mshr_ack_cache_tag_i, mshr_ack_word_i, mshr_ack_need_rsp_i, mshr_ack_is_prefetch_i, mshr_ack_wback_i  in  typed  entry contents, valid the cycle after the ack
- refill_write_valid_o / refill_write_ready_i  out/in  1  cache line write handshake
- refill_set_o / refill_way_o / refill_tag_o  out  typed  write target
- refill_data_o  out  clWords*wordWidth  line data
- refill_dirty_o  out  1  line installed dirty (wback)
- core_rsp_valid_o  out  1  core response strobe, no backpressure
- core_rsp_req_id_o / core_rsp_src_id_o  out  typed  response identifiers
- core_rsp_data_o  out  wordWidth  response word
- core_rsp_error_o  out  1  response error
- busy_o  out  1  high whenever the FSM is not in IDLE

## Operation

- Beats per line: BEATS = clWords*wordWidth/memDataWidth. BEATS must be at least 1.
- FSM states: IDLE, COLLECT, ACK_REQ, ACK_RD, WRITE, RSP.
- IDLE / COLLECT:
  - mem_rsp_ready_o = 1.
  - Each accepted beat goes to line buffer slot beat_cnt; beat_cnt then increments.
  - The first beat latches mem_rsp_id_i.
  - err_q ORs in mem_rsp_error_i on every beat.
  - A beat with last=1 moves to ACK_REQ. Otherwise the FSM moves to, or stays in, COLLECT.
  - A single-beat line goes IDLE→ACK_REQ directly.
- ACK_REQ:
  - refill_req_o = 1.
  - While refill_gnt_i = 1 in the same cycle: mshr_ack_o = mshr_ack_cs_o = 1, with set and way taken from the latched id. The FSM then moves to ACK_RD.
  - The grant guarantees no concurrent MSHR alloc or check.
- ACK_RD: all mshr_ack_*_i are registered into a metadata register, then:
  - err_q = 0 → WRITE.
  - err_q = 1 → RSP.
- WRITE:
  - refill_write_valid_o = 1 until refill_write_ready_i.
  - Outputs carry the captured set, way and tag, the buffer contents, and refill_dirty_o = wback.
  - On the handshake: need_rsp & ~is_prefetch → RSP; otherwise → IDLE.
- RSP:
  - Entered only when need_rsp & ~is_prefetch, or on error. On error with need_rsp = 0 or is_prefetch = 1, the FSM goes to IDLE with no response.
  - core_rsp_valid_o = 1 for one cycle.
  - core_rsp_data_o = buffer word at the captured word index.
  - core_rsp_error_o = err_q.
  - Next state: IDLE.
- Errored lines are never written to the cache. The MSHR entry is still acknowledged.
- beat_cnt wraps to 0 on leaving COLLECT.
- last asserted with beat_cnt ≠ BEATS-1 is a protocol error: assertion only, no recovery logic.
- Asynchronous reset at any state:
  - FSM returns to IDLE; beat_cnt, err_q and the id/metadata registers clear.
  - A partially collected line is discarded.

## Timing

- Reset values:
  - mem_rsp_ready_o = 1; busy_o = 0.
  - All other outputs 0.
- Latency for an N-beat line with no stalls, last beat accepted in cycle t:
  - refill_req_o at t+1; ack at t+1 if granted.
  - Metadata capture at t+2.
  - refill_write_valid_o at t+3.
  - core_rsp_valid_o at t+4.
  - mem_rsp_ready_o high again at t+5.
- mem_rsp_ready_o is low from ACK_REQ through RSP: one line in flight.
- mshr_ack_o is combinational from refill_gnt_i and never asserts outside ACK_REQ.
- refill_write_valid_o holds stable with constant payload until ready.

## Structure

- Shared constants go in hpdcache_pkg: the BEATS computation and the MSHR-id width (mshrSetWidth + mshrWayWidth).
- The FSM state enum stays local.
- Sub-module hpdcache_mshr_refill_buf: a BEATS×memDataWidth line buffer with write-by-beat-index and a word-index read port. It is flops only, with no reset on data.

## Test plan

Config: mshrSets=4, mshrWays=2, clWords=8, wordWidth=64, memDataWidth=128 (BEATS=4).

- 4 beats, id=3'b101, grant held high; MSHR returns set=0x1A, way=2, word=5, need_rsp=1, wback=0.
  - mshr_ack_o at t+1 with way=1, set=1.
  - Write of the assembled line at t+3 with dirty=0.
  - core_rsp at t+4 with data = beat2[127:64], error=0.
- Same line with refill_grant low for 3 cycles.
  - refill_req_o held; ack only in the grant cycle; latencies shift by 3.
- Beat 1 with error=1, need_rsp=1.
  - No refill_write_valid_o; core_rsp_error_o=1 at t+3.
  - MSHR still acknowledged.
- Prefetch entry (is_prefetch=1, wback=1).
  - Write with refill_dirty_o=1, no core_rsp, IDLE at t+4.
- refill_write_ready_i low for 5 cycles.
  - Valid and payload stable; mem_rsp_ready_o stays 0.
- rst_ni asserted after beat 2.
  - All outputs at reset values.
  - The next 4-beat line is collected correctly from slot 0.
